cache_port_arbiter: RTL

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/cache_port_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares a single cache port between NUM_PORTS masters. Each master runs a
// 4-phase request/valid handshake with the arbiter; the arbiter runs its own
// 4-phase handshake with the cache. Masters are served one at a time in
// round-robin order starting after the most recently served port.
//
// Ports:
//   clock, reset_n          clock (rising edge) and synchronous active-low reset
//   m_request[NUM_PORTS]    per-master request
//   m_op/m_addr/m_wdata     per-master op/address/write data, port i at [i*W +: W]
//   m_valid, m_evict        per-master completion and evict flag (granted port only)
//   m_rdata                 read data broadcast to every master, qualified by m_valid
//   s_request/s_op/s_addr/s_wdata   request towards the cache, stable while busy
//   s_valid/s_evict/s_rdata completion, evict flag and read data from the cache
//   grant_id                index of the master being served
//   busy                    high whenever the arbiter is not idle
//   err_clear, timeout_err  sticky cache-timeout flag and its clear
//
// Every output is a register.
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 32,
    parameter int OP_W      = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           m_request,
    input  logic [NUM_PORTS*OP_W-1:0]      m_op,
    input  logic [NUM_PORTS*ADDR_W-1:0]    m_addr,
    input  logic [NUM_PORTS*WORD_W-1:0]    m_wdata,
    output logic [NUM_PORTS-1:0]           m_valid,
    output logic [NUM_PORTS-1:0]           m_evict,
    output logic [WORD_W-1:0]              m_rdata,
    output logic                           s_request,
    output logic [OP_W-1:0]                s_op,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [WORD_W-1:0]              s_wdata,
    input  logic                           s_valid,
    input  logic                           s_evict,
    input  logic [WORD_W-1:0]              s_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
    output logic                           busy,
    input  logic                           err_clear,
    output logic                           timeout_err
);

    localparam int          GW          = $clog2(NUM_PORTS);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, ACK, DROP} state_t;

    state_t               state_reg, state_next;
    logic [GW-1:0]        last_grant_reg, last_grant_next;
    logic [15:0]          cnt_reg, cnt_next;
    logic                 dropped_reg, dropped_next;

    logic [GW-1:0]        grant_next;
    logic                 s_request_next;
    logic [OP_W-1:0]      s_op_next;
    logic [ADDR_W-1:0]    s_addr_next;
    logic [WORD_W-1:0]    s_wdata_next;
    logic [NUM_PORTS-1:0] m_valid_next, m_evict_next;
    logic [WORD_W-1:0]    m_rdata_next;
    logic                 busy_next, timeout_err_next;

    // Per-port views of the packed master buses.
    logic [OP_W-1:0]      op_arr    [NUM_PORTS];
    logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
    logic [WORD_W-1:0]    wdata_arr [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign op_arr[gi]    = m_op[gi*OP_W +: OP_W];
        assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = m_wdata[gi*WORD_W +: WORD_W];
    end

    logic [NUM_PORTS-1:0] grant_onehot;
    assign grant_onehot = NUM_PORTS'(1) << grant_id;

    // Round-robin search: first requester strictly after last_grant, wrapping.
    logic          rr_found;
    logic [GW-1:0] rr_win;
    int            rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            rr_idx = int'(last_grant_reg) + k;
            if (rr_idx >= NUM_PORTS) begin
                rr_idx = rr_idx - NUM_PORTS;
            end
            if (!rr_found && m_request[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_grant_next  = last_grant_reg;
        cnt_next         = cnt_reg;
        dropped_next     = dropped_reg;
        grant_next       = grant_id;
        s_request_next   = s_request;
        s_op_next        = s_op;
        s_addr_next      = s_addr;
        s_wdata_next     = s_wdata;
        m_valid_next     = m_valid;
        m_evict_next     = m_evict;
        m_rdata_next     = m_rdata;
        timeout_err_next = timeout_err;

        // Clear first so that a timeout detected below in the same cycle wins.
        if (err_clear) begin
            timeout_err_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    state_next     = REQ;
                    grant_next     = rr_win;
                    s_request_next = 1'b1;
                    s_op_next      = op_arr[rr_win];
                    s_addr_next    = addr_arr[rr_win];
                    s_wdata_next   = wdata_arr[rr_win];
                    cnt_next       = '0;
                    dropped_next   = 1'b0;
                end
            end
            REQ: begin
                // A master that withdraws early still gets its completion,
                // but only for a single cycle.
                if (!m_request[grant_id]) begin
                    dropped_next = 1'b1;
                end
                if (s_valid) begin
                    state_next   = ACK;
                    m_rdata_next = s_rdata;
                    m_valid_next = grant_onehot;
                    m_evict_next = s_evict ? grant_onehot : '0;
                end else if (cnt_reg != TIMEOUT_LIM) begin
                    // Counter saturates so the flag is raised only once per wait.
                    cnt_next = cnt_reg + 16'd1;
                    if (cnt_reg + 16'd1 == TIMEOUT_LIM) begin
                        timeout_err_next = 1'b1;
                    end
                end
            end
            ACK: begin
                if (!m_request[grant_id] || dropped_reg) begin
                    state_next     = DROP;
                    m_valid_next   = '0;
                    m_evict_next   = '0;
                    s_request_next = 1'b0;
                end
            end
            DROP: begin
                if (!s_valid) begin
                    state_next      = IDLE;
                    last_grant_next = grant_id;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(NUM_PORTS - 1);
            cnt_reg        <= '0;
            dropped_reg    <= 1'b0;
            grant_id       <= '0;
            s_request      <= 1'b0;
            s_op           <= '0;
            s_addr         <= '0;
            s_wdata        <= '0;
            m_valid        <= '0;
            m_evict        <= '0;
            m_rdata        <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            dropped_reg    <= dropped_next;
            grant_id       <= grant_next;
            s_request      <= s_request_next;
            s_op           <= s_op_next;
            s_addr         <= s_addr_next;
            s_wdata        <= s_wdata_next;
            m_valid        <= m_valid_next;
            m_evict        <= m_evict_next;
            m_rdata        <= m_rdata_next;
            busy           <= busy_next;
            timeout_err    <= timeout_err_next;
        end
    end

endmodule
